// File: rtl/muldiv_seq_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_unit_pkg
//  Description : Shared definitions for the sequential RV32M multiply/divide
//                unit: default widths, funct3 op encodings, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_seq_unit_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int HART_ID_W_DEF  = 1;
    localparam int REG_ADDR_W_DEF = 5;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'd0,
        MULDIV_MULH   = 3'd1,
        MULDIV_MULHSU = 3'd2,
        MULDIV_MULHU  = 3'd3,
        MULDIV_DIV    = 3'd4,
        MULDIV_DIVU   = 3'd5,
        MULDIV_REM    = 3'd6,
        MULDIV_REMU   = 3'd7
    } muldiv_op_e;

    // Sequencer states: idle, iterate one bit per cycle, finalize result
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } muldiv_state_e;

endpackage : muldiv_seq_unit_pkg
`default_nettype wire

// File: rtl/muldiv_seq_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_unit_if
//  Description : Request/response bundle between the core (master) and the
//                multiply/divide unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_seq_unit_if #(
    parameter int XLEN       = 32,
    parameter int HART_ID_W  = 1,
    parameter int REG_ADDR_W = 5
) ();
    logic                  muldiv_start;
    logic [2:0]            muldiv_op;
    logic [XLEN-1:0]       muldiv_a;
    logic [XLEN-1:0]       muldiv_b;
    logic [HART_ID_W-1:0]  muldiv_hart_id;
    logic [REG_ADDR_W-1:0] muldiv_rd;
    logic                  muldiv_busy;
    logic                  muldiv_done;
    logic [XLEN-1:0]       muldiv_result;
    logic [HART_ID_W-1:0]  muldiv_done_hart_id;
    logic [REG_ADDR_W-1:0] muldiv_done_rd;

    modport master (
        output muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
        input  muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd
    );

    modport slave (
        input  muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
        output muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd
    );
endinterface : muldiv_seq_unit_if
`default_nettype wire

// File: rtl/muldiv_seq_unit_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_unit_iter
//  Description : Radix-2 step datapath on unsigned magnitudes. Multiply is
//                shift-add (product ends in {hi,lo}); divide is restoring
//                (quotient ends in lo, remainder in hi).
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq_unit_iter #(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            load,
    input  wire logic            step,
    input  wire logic            is_div,
    input  wire logic [XLEN-1:0] a_mag,
    input  wire logic [XLEN-1:0] b_mag,
    output logic      [XLEN-1:0] hi,
    output logic      [XLEN-1:0] lo
);
    // hi carries one extra bit so the multiply partial sum never overflows
    logic [XLEN:0]   r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opnd;   // multiplicand or divisor

    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;
    logic            w_qbit;
    logic [XLEN:0]   w_next_hi;
    logic [XLEN-1:0] w_next_lo;

    // Next-step values for both algorithms, selected by operation class
    always_comb begin
        w_mul_sum   = r_hi + {1'b0, (r_lo[0] ? r_opnd : '0)};
        w_div_shift = {r_hi[XLEN-1:0], r_lo[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        w_qbit      = ~w_div_diff[XLEN];
        if (is_div) begin
            w_next_hi = w_qbit ? w_div_diff : w_div_shift;
            w_next_lo = {r_lo[XLEN-2:0], w_qbit};
        end else begin
            w_next_hi = {1'b0, w_mul_sum[XLEN:1]};
            w_next_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // Load operands on accept, advance one bit per step cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
        end else if (load) begin
            r_hi   <= '0;
            r_lo   <= a_mag;
            r_opnd <= b_mag;
        end else if (step) begin
            r_hi   <= w_next_hi;
            r_lo   <= w_next_lo;
        end
    end

    assign hi = r_hi[XLEN-1:0];
    assign lo = r_lo;

endmodule : muldiv_seq_unit_iter
`default_nettype wire

// File: rtl/muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_unit
//  Description : Shared multi-cycle RV32M multiply/divide unit with hart/rd
//                tagging. Fixed XLEN+1 cycle accept-to-done latency for all
//                operations, including divide-by-zero and signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq_unit
    import muldiv_seq_unit_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int HART_ID_W  = HART_ID_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst_n,   // active-high synchronous reset
    muldiv_seq_unit_if.slave bus
);
    localparam int                CNT_W       = $clog2(XLEN);
    localparam logic [CNT_W-1:0]  c_last_iter = CNT_W'(XLEN - 1);

    muldiv_state_e         r_state;
    logic [CNT_W-1:0]      r_cnt;
    muldiv_op_e            r_op;
    logic [XLEN-1:0]       r_a;
    logic                  r_neg_q;     // product/quotient must be negated
    logic                  r_neg_r;     // remainder must be negated
    logic                  r_b_zero;
    logic                  r_is_div;
    logic [HART_ID_W-1:0]  r_hart;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_busy;
    logic                  r_done;
    logic [XLEN-1:0]       r_result;
    logic [HART_ID_W-1:0]  r_done_hart;
    logic [REG_ADDR_W-1:0] r_done_rd;

    muldiv_op_e            w_op;
    logic                  w_accept;
    logic                  w_a_signed;
    logic                  w_b_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [XLEN-1:0]       w_a_mag;
    logic [XLEN-1:0]       w_b_mag;
    logic [XLEN-1:0]       w_core_hi;
    logic [XLEN-1:0]       w_core_lo;
    logic [2*XLEN-1:0]     w_prod;
    logic [2*XLEN-1:0]     w_prod_s;
    logic [XLEN-1:0]       w_quot;
    logic [XLEN-1:0]       w_rem;
    logic [XLEN-1:0]       w_result;

    assign w_op     = muldiv_op_e'(bus.muldiv_op);
    assign w_accept = bus.muldiv_start && !r_busy;

    // Operand signedness and magnitudes; MUL low half is sign-agnostic
    always_comb begin
        w_a_signed = (w_op == MULDIV_MULH) || (w_op == MULDIV_MULHSU) ||
                     (w_op == MULDIV_DIV)  || (w_op == MULDIV_REM);
        w_b_signed = (w_op == MULDIV_MULH) || (w_op == MULDIV_DIV) ||
                     (w_op == MULDIV_REM);
        w_a_neg    = w_a_signed && bus.muldiv_a[XLEN-1];
        w_b_neg    = w_b_signed && bus.muldiv_b[XLEN-1];
        w_a_mag    = w_a_neg ? -bus.muldiv_a : bus.muldiv_a;
        w_b_mag    = w_b_neg ? -bus.muldiv_b : bus.muldiv_b;
    end

    muldiv_seq_unit_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk    (clk),
        .rst    (rst_n),
        .load   (w_accept),
        .step   (r_state == ST_ITER),
        .is_div (r_is_div),
        .a_mag  (w_a_mag),
        .b_mag  (w_b_mag),
        .hi     (w_core_hi),
        .lo     (w_core_lo)
    );

    // Sign fix-up and special-case result selection from the finished core
    always_comb begin
        w_prod   = {w_core_hi, w_core_lo};
        w_prod_s = r_neg_q ? -w_prod : w_prod;
        w_quot   = r_neg_q ? -w_core_lo : w_core_lo;
        w_rem    = r_neg_r ? -w_core_hi : w_core_hi;
        w_result = '0;
        case (r_op)
            MULDIV_MUL:                               w_result = w_prod_s[XLEN-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: w_result = w_prod_s[2*XLEN-1:XLEN];
            MULDIV_DIV, MULDIV_DIVU:                  w_result = r_b_zero ? '1 : w_quot;
            MULDIV_REM, MULDIV_REMU:                  w_result = r_b_zero ? r_a : w_rem;
            default:                                  w_result = '0;
        endcase
    end

    // Sequencer: accept, iterate XLEN cycles, then publish result and tags
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= MULDIV_MUL;
            r_a         <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_b_zero    <= 1'b0;
            r_is_div    <= 1'b0;
            r_hart      <= '0;
            r_rd        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_done_hart <= '0;
            r_done_rd   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_op;
                        r_a      <= bus.muldiv_a;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_b_zero <= (bus.muldiv_b == '0);
                        r_is_div <= bus.muldiv_op[2];
                        r_hart   <= bus.muldiv_hart_id;
                        r_rd     <= bus.muldiv_rd;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_iter) begin
                        r_state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_result    <= w_result;
                    r_done_hart <= r_hart;
                    r_done_rd   <= r_rd;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.muldiv_busy         = r_busy;
    assign bus.muldiv_done         = r_done;
    assign bus.muldiv_result       = r_result;
    assign bus.muldiv_done_hart_id = r_done_hart;
    assign bus.muldiv_done_rd      = r_done_rd;

endmodule : muldiv_seq_unit
`default_nettype wire

// File: tb/tb_muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq_unit
//  Description : Scoreboard bench for muldiv_seq_unit with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq_unit;
    import muldiv_seq_unit_pkg::*;

    localparam int LAT = 33;

    typedef struct {
        logic [31:0] res;
        logic        hart;
        logic [4:0]  rd;
        int          acc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        hart;
        logic [4:0]  rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[$];

    muldiv_seq_unit_if #(.XLEN(32), .HART_ID_W(1), .REG_ADDR_W(5)) bus ();

    muldiv_seq_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request once the unit is free; optionally record expectation
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic hart, input logic [4:0] rd, input logic [31:0] res,
                         input bit push);
        int g = 0;
        exp_t e;
        @(negedge clk);
        while (bus.muldiv_busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("issue_timeout", 64'(bus.muldiv_busy), 64'd0);
        if (g > 0) check("b2b_in_done_cycle", 64'(bus.muldiv_done), 64'd1);
        bus.muldiv_start   = 1'b1;
        bus.muldiv_op      = op;
        bus.muldiv_a       = a;
        bus.muldiv_b       = b;
        bus.muldiv_hart_id = hart;
        bus.muldiv_rd      = rd;
        @(posedge clk);
        #1;
        if (push) begin
            e.res  = res;
            e.hart = hart;
            e.rd   = rd;
            e.acc  = cyc;
            sb.push_back(e);
        end
        bus.muldiv_start = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || bus.muldiv_busy) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n && bus.muldiv_done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 result=%0h expected no completion", bus.muldiv_result);
            end else begin
                e = sb.pop_front();
                check("result",       64'(bus.muldiv_result),       64'(e.res));
                check("done_hart_id", 64'(bus.muldiv_done_hart_id), 64'(e.hart));
                check("done_rd",      64'(bus.muldiv_done_rd),      64'(e.rd));
                check("latency",      64'(cyc - e.acc),             64'(LAT));
                check("busy_at_done", 64'(bus.muldiv_busy),         64'd0);
            end
        end
    end

    initial begin
        bus.muldiv_start   = 1'b0;
        bus.muldiv_op      = 3'd0;
        bus.muldiv_a       = '0;
        bus.muldiv_b       = '0;
        bus.muldiv_hart_id = 1'b0;
        bus.muldiv_rd      = '0;

        vecs.push_back('{MULDIV_MUL,    32'd10,         32'd3,          32'd30,         1'b0, 5'd3});
        vecs.push_back('{MULDIV_DIV,    32'd10,         32'd3,          32'd3,          1'b1, 5'd4});
        vecs.push_back('{MULDIV_REM,    32'd10,         32'd3,          32'd1,          1'b0, 5'd5});
        vecs.push_back('{MULDIV_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   1'b1, 5'd6});
        vecs.push_back('{MULDIV_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   1'b0, 5'd7});
        vecs.push_back('{MULDIV_MULHSU, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   1'b1, 5'd8});
        vecs.push_back('{MULDIV_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   1'b0, 5'd9});
        vecs.push_back('{MULDIV_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b1, 5'd11});
        vecs.push_back('{MULDIV_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0, 5'd12});
        vecs.push_back('{MULDIV_DIVU,   32'd100,        32'd7,          32'd14,         1'b1, 5'd13});
        vecs.push_back('{MULDIV_REMU,   32'd100,        32'd7,          32'd2,          1'b0, 5'd14});
        vecs.push_back('{MULDIV_DIV,    32'd5,          32'd0,          32'hFFFFFFFF,   1'b1, 5'd15});
        vecs.push_back('{MULDIV_DIVU,   32'd5,          32'd0,          32'hFFFFFFFF,   1'b0, 5'd16});
        vecs.push_back('{MULDIV_REM,    32'd5,          32'd0,          32'd5,          1'b1, 5'd17});
        vecs.push_back('{MULDIV_DIV,    32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1'b0, 5'd18});
        vecs.push_back('{MULDIV_REM,    32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1'b1, 5'd19});
        vecs.push_back('{MULDIV_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, 5'd20});
        vecs.push_back('{MULDIV_REM,    32'h80000000,   32'hFFFFFFFF,   32'h00000000,   1'b1, 5'd21});

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        check("rst_busy",      64'(bus.muldiv_busy),         64'd0);
        check("rst_done",      64'(bus.muldiv_done),         64'd0);
        check("rst_result",    64'(bus.muldiv_result),       64'd0);
        check("rst_done_hart", 64'(bus.muldiv_done_hart_id), 64'd0);
        check("rst_done_rd",   64'(bus.muldiv_done_rd),      64'd0);

        // Directed vectors, each issued in the done cycle of the previous one
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hart, vecs[i].rd, vecs[i].res, 1'b1);
        end
        drain();

        // Start while busy must be ignored
        issue(MULDIV_MUL, 32'd6, 32'd7, 1'b1, 5'd10, 32'd42, 1'b1);
        repeat (5) @(negedge clk);
        check("busy_mid_op", 64'(bus.muldiv_busy), 64'd1);
        bus.muldiv_start   = 1'b1;
        bus.muldiv_op      = MULDIV_DIV;
        bus.muldiv_a       = 32'd9;
        bus.muldiv_b       = 32'd3;
        bus.muldiv_hart_id = 1'b0;
        bus.muldiv_rd      = 5'd4;
        repeat (3) @(negedge clk);
        bus.muldiv_start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Reset ten cycles after accept aborts the operation
        issue(MULDIV_MUL, 32'd123, 32'd456, 1'b0, 5'd31, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check("abort_busy",      64'(bus.muldiv_busy),         64'd0);
        check("abort_done",      64'(bus.muldiv_done),         64'd0);
        check("abort_result",    64'(bus.muldiv_result),       64'd0);
        check("abort_done_hart", 64'(bus.muldiv_done_hart_id), 64'd0);
        check("abort_done_rd",   64'(bus.muldiv_done_rd),      64'd0);
        repeat (40) @(negedge clk);
        check("abort_result_held", 64'(bus.muldiv_result), 64'd0);

        // Normal operation after reset
        issue(MULDIV_MULHU, 32'h00010000, 32'h00010000, 1'b1, 5'd7, 32'd1, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_muldiv_seq_unit
`default_nettype wire

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
Shared multi-cycle RV32M multiply/divide coprocessor for the barrel-threaded CPU core. It accepts one operation at a time, tagged with the issuing hart and destination register. It returns the result with the same tags after a fixed latency, so the core can keep running other harts while one hart waits.

Parameters:
XLEN, 32, operand/result width
HART_ID_W, 1, hart tag width
REG_ADDR_W, 5, destination register tag width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; synchronous, active-high (asserted = 1), port name kept per codebase convention
muldiv_start  in  1  request strobe; accepted only when muldiv_busy=0
muldiv_op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
muldiv_a  in  XLEN  rs1 operand
muldiv_b  in  XLEN  rs2 operand
muldiv_hart_id  in  HART_ID_W  issuing hart tag
muldiv_rd  in  REG_ADDR_W  destination register tag
muldiv_busy  out  1  operation in flight
muldiv_done  out  1  one-cycle completion pulse
muldiv_result  out  XLEN  result; valid while done=1, held afterwards
muldiv_done_hart_id  out  HART_ID_W  tag captured at accept
muldiv_done_rd  out  REG_ADDR_W  tag captured at accept

Behaviour:
- Reset (rst_n=1 at an edge): busy=0, done=0, result=0, done_hart_id=0, done_rd=0. Iteration counter and datapath are cleared. Any in-flight operation is aborted and produces no done pulse.
- Accept: at the edge where start=1 and busy=0 (call it edge N), the unit latches op, operands, hart_id and rd. busy=1 from N.
- start while busy=1 is ignored entirely. The latched state and tags are not modified.
- Iteration: radix-2, one bit per cycle, XLEN iterations.
  - Multiply: shift-add on operand magnitudes, 2*XLEN-bit product. Sign correction per op: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Divide: restoring division on magnitudes. Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Completion: at edge N+XLEN+1:
  - done=1 for exactly one cycle.
  - result is loaded.
  - busy=0 in that same cycle.
- Fixed latency for all ops, including special cases. Total accept-to-done is XLEN+1 cycles (33 at default).
- A start asserted during the done cycle is accepted (busy=0), giving back-to-back throughput.
- Result selection:
  - MUL: product[XLEN-1:0].
  - MULH, MULHSU, MULHU: product[2XLEN-1:XLEN].
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Divide by zero: DIV/DIVU return all ones (0xFFFFFFFF). REM/REMU return a.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- The result register and done tags hold their values until the next completion.
- The unit never reads or writes register files. Writeback is the core's job, using the done tags.

Decomposition:
- Shared package (rv32m_pkg): op encodings (MULDIV_MUL … MULDIV_REMU), XLEN/HART_ID_W/REG_ADDR_W defaults.
- Single module is natural.
- Optional sub-module: muldiv_iter_core (shift-add/restoring-divide step datapath), with sign fix-up and special cases kept in the top.

Test Plan:
- MUL a=10, b=3, hart=0, rd=3 -> done exactly 33 cycles after accept, result=30, done_hart_id=0, done_rd=3. Then DIV 10/3 -> 3, then REM 10%3 -> 1, each issued in the prior done cycle.
- Signed/unsigned high: MULH 0xFFFFFFFF×0xFFFFFFFF -> 0. MULHU same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF. DIV -7/2 -> 0xFFFFFFFD (-3). REM -7%2 -> 0xFFFFFFFF (-1).
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF. DIVU 5/0 -> 0xFFFFFFFF. REM 5%0 -> 5. Latency still 33 cycles.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Busy rejection: accept MUL 6×7 (hart 1, rd 10), then assert start with DIV 9/3 (hart 0, rd 4) mid-operation -> only one done, result=42, tags 1/10.
- Reset mid-operation: rst_n=1 ten cycles after accept -> busy=0, done never pulses, result=0, done tags=0. The next request after reset completes normally.
